// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_t      : controller FSM states (RUN, MEM_WAIT)
//   FWD_*        : EX operand source selects driven on fwd0_sel/fwd1_sel
//   WD_SEL_LOAD  : writeback-select code that marks a load instruction
//   SEG_*        : bit positions of the segment registers in en_s/stall_s/flush_s
//   sat_inc()    : saturating increment used by the performance counters
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF       = 2'b00;
    localparam logic [1:0] FWD_MEM_ALU  = 2'b01;
    localparam logic [1:0] FWD_WB       = 2'b10;
    localparam logic [1:0] FWD_MEM_LOAD = 2'b11;

    localparam logic [1:0] WD_SEL_LOAD  = 2'b10;

    localparam int SEG_IF_ID  = 0;
    localparam int SEG_ID_EX  = 1;
    localparam int SEG_EX_MEM = 2;
    localparam int SEG_MEM_WB = 3;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        logic [31:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Forwarding selector for one EX-stage source operand.
//   ex_ra      : EX source register address
//   mem_wa/we/wd_sel : MEM-stage destination, write enable, writeback select
//   wb_wa/we   : WB-stage destination and write enable
//   fwd_sel    : operand source (register file, MEM ALU, WB data, MEM load data)
// The younger MEM-stage producer wins over WB; x0 is never forwarded.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_ra,
    input  logic [4:0] mem_wa,
    input  logic       mem_we,
    input  logic [1:0] mem_wd_sel,
    input  logic [4:0] wb_wa,
    input  logic       wb_we,
    output logic [1:0] fwd_sel
);

    // Priority match: MEM stage first, then WB, else register file.
    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_we && (mem_wa != 5'd0) && (mem_wa == ex_ra)) begin
            if (mem_wd_sel == WD_SEL_LOAD) begin
                fwd_sel = FWD_MEM_LOAD;
            end else begin
                fwd_sel = FWD_MEM_ALU;
            end
        end else if (wb_we && (wb_wa != 5'd0) && (wb_wa == ex_ra)) begin
            fwd_sel = FWD_WB;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline.
// Inputs : clk, rst (sync, active-high), ID/EX/MEM/WB register address and
//          write fields, ex_br_taken, mem_access, dmem_ready.
// Outputs: dmem_req (request pulse), pc_stall, per-segment en_s/stall_s/
//          flush_s (bit0 IF/ID .. bit3 MEM/WB), fwd0_sel/fwd1_sel, and the
//          saturating stall_cnt/flush_cnt performance counters.
// A data-memory access that is not ready freezes the whole pipeline; while
// not frozen, a taken branch flushes IF/ID and ID/EX, otherwise a load-use
// hazard stalls IF/ID and inserts a bubble into ID/EX.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_ra0,
    input  logic [4:0]  id_ra1,
    input  logic [4:0]  ex_ra0,
    input  logic [4:0]  ex_ra1,
    input  logic [4:0]  ex_wa,
    input  logic        ex_we,
    input  logic [1:0]  ex_wd_sel,
    input  logic [4:0]  mem_wa,
    input  logic        mem_we,
    input  logic [1:0]  mem_wd_sel,
    input  logic [4:0]  wb_wa,
    input  logic        wb_we,
    input  logic        ex_br_taken,
    input  logic        mem_access,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        pc_stall,
    output logic [3:0]  en_s,
    output logic [3:0]  stall_s,
    output logic [3:0]  flush_s,
    output logic [1:0]  fwd0_sel,
    output logic [1:0]  fwd1_sel,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    state_t      state_q;
    state_t      state_d;
    state_t      state_cur;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] flush_cnt_q;
    logic [31:0] flush_cnt_d;
    logic        freeze;
    logic        load_use;
    logic        lu_stall;

    // State register and counters.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    // Reset forces the combinational view of the state to RUN immediately,
    // so an access pending at reset is abandoned without a new request.
    always_comb begin
        if (rst) begin
            state_cur = ST_RUN;
        end else begin
            state_cur = state_q;
        end
    end

    // Freeze: memory access not completing this cycle; load-use detection.
    always_comb begin
        if (state_cur == ST_MEM_WAIT) begin
            freeze = ~dmem_ready;
        end else begin
            freeze = mem_access & ~dmem_ready;
        end
        load_use = ex_we && (ex_wd_sel == WD_SEL_LOAD) && (ex_wa != 5'd0) &&
                   ((ex_wa == id_ra0) || (ex_wa == id_ra1));
        // A taken branch squashes the dependent instruction, so no stall then.
        lu_stall = load_use & ~ex_br_taken & ~freeze;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_cur;
        if (rst) begin
            state_d = ST_RUN;
        end else begin
            case (state_cur)
                ST_RUN: begin
                    if (mem_access && !dmem_ready) begin
                        state_d = ST_MEM_WAIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_MEM_WAIT;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Performance counter updates.
    always_comb begin
        if (rst) begin
            stall_cnt_d = 32'd0;
            flush_cnt_d = 32'd0;
        end else begin
            if (freeze || lu_stall) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
            if (!freeze && ex_br_taken) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end else begin
                flush_cnt_d = flush_cnt_q;
            end
        end
    end

    // Output decode: freeze > branch flush > load-use bubble.
    always_comb begin
        en_s     = 4'b1111;
        stall_s  = 4'b0000;
        flush_s  = 4'b0000;
        pc_stall = 1'b0;
        dmem_req = 1'b0;
        if ((state_cur == ST_RUN) && mem_access && !rst) begin
            dmem_req = 1'b1;
        end else begin
            dmem_req = 1'b0;
        end
        if (freeze) begin
            en_s     = 4'b0000;
            pc_stall = 1'b1;
        end else if (ex_br_taken) begin
            flush_s[SEG_IF_ID] = 1'b1;
            flush_s[SEG_ID_EX] = 1'b1;
        end else if (load_use) begin
            pc_stall           = 1'b1;
            stall_s[SEG_IF_ID] = 1'b1;
            flush_s[SEG_ID_EX] = 1'b1;
        end else begin
            en_s = 4'b1111;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    fwd_unit u_fwd0 (
        .ex_ra      (ex_ra0),
        .mem_wa     (mem_wa),
        .mem_we     (mem_we),
        .mem_wd_sel (mem_wd_sel),
        .wb_wa      (wb_wa),
        .wb_we      (wb_we),
        .fwd_sel    (fwd0_sel)
    );

    fwd_unit u_fwd1 (
        .ex_ra      (ex_ra1),
        .mem_wa     (mem_wa),
        .mem_we     (mem_we),
        .mem_wd_sel (mem_wd_sel),
        .wb_wa      (wb_wa),
        .wb_we      (wb_we),
        .fwd_sel    (fwd1_sel)
    );

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have ports id_ra0 and id_ra1, input, 5 each: ID-stage source register addresses.
REQ-004 SHALL have ports ex_ra0 and ex_ra1, input, 5 each: EX-stage source register addresses.
REQ-005 SHALL have ports ex_wa (5), ex_we (1) and ex_wd_sel (2), input: EX-stage destination, write enable and writeback select; 2'b10 means load.
REQ-006 SHALL have ports mem_wa (5), mem_we (1) and mem_wd_sel (2), input: MEM-stage destination fields.
REQ-007 SHALL have ports wb_wa (5) and wb_we (1), input: WB-stage destination fields.
REQ-008 SHALL have port ex_br_taken, input, 1: taken branch or jump resolved in EX.
REQ-009 SHALL have port mem_access, input, 1: a valid load or store is in MEM.
REQ-010 SHALL have port dmem_ready, input, 1: data memory completes the access this cycle.
REQ-011 SHALL have port dmem_req, output, 1: one-cycle request pulse to data memory.
REQ-012 SHALL have port pc_stall, output, 1: hold PC.
REQ-013 SHALL have ports en_s, stall_s and flush_s, output, 4 each: per segment register; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB.
REQ-014 SHALL have ports fwd0_sel and fwd1_sel, output, 2 each: EX operand source; 00 register file, 01 MEM ALU result, 10 WB data, 11 MEM load data.
REQ-015 SHALL have ports stall_cnt and flush_cnt, output, 32 each: performance counters.

Function
REQ-016 SHALL implement FSM states RUN and MEM_WAIT.
REQ-017 SHALL assert dmem_req for one cycle when state is RUN and mem_access=1; SHALL keep it low in MEM_WAIT.
REQ-018 SHALL go RUN->MEM_WAIT when state is RUN, mem_access=1 and dmem_ready=0; SHALL go MEM_WAIT->RUN on dmem_ready=1.
REQ-019 SHALL compute freeze = mem_access & ~dmem_ready in RUN, and ~dmem_ready in MEM_WAIT.
REQ-020 During freeze, SHALL drive en_s=4'b0000, pc_stall=1, stall_s=0 and flush_s=0, overriding every other condition.
REQ-021 Otherwise SHALL drive en_s=4'b1111.
REQ-022 SHALL detect load-use when ex_we=1, ex_wd_sel=2'b10, ex_wa!=0 and ex_wa equals id_ra0 or id_ra1.
REQ-023 On load-use without branch, SHALL drive pc_stall=1, stall_s[0]=1 and flush_s[1]=1 (bubble).
REQ-024 On ex_br_taken without freeze, SHALL drive flush_s[0]=1 and flush_s[1]=1 and no stall, superseding load-use.
REQ-025 SHALL compute forwarding per operand: MEM match first (mem_we, mem_wa!=0, mem_wa==ex_raN gives 11 if mem_wd_sel=2'b10, else 01); then WB match (10); else 00.
REQ-026 SHALL never forward register 0; forwarding SHALL be combinational and independent of freeze.
REQ-027 SHALL increment stall_cnt on each cycle with freeze or load-use stall, saturating at 32'hFFFF_FFFF.
REQ-028 SHALL increment flush_cnt on each non-frozen cycle with ex_br_taken, saturating.
REQ-029 Freeze and a branch in the same cycle SHALL be handled by freezing; the branch SHALL take effect on the first unfrozen cycle.

Reset
REQ-030 On rst, SHALL set state to RUN and stall_cnt and flush_cnt to 0, and SHALL drive dmem_req=0 that cycle.
REQ-031 Reset mid-MEM_WAIT SHALL abandon the access, with no dmem_req on the reset cycle.
REQ-032 Combinational outputs during reset SHALL follow the REQ-019..026 equations, with state taken as RUN.

Structure
REQ-033 Package pipe_ctrl_pkg SHALL hold the FSM state enum, the fwd_sel constants (00/01/10/11), the wd_sel load encoding 2'b10 and the segment bit indices.
REQ-034 Forwarding logic SHALL live in one sub-module fwd_unit, instantiated once per operand.

Verification
REQ-035 Load to x5 in EX with id_ra1=5 -> pc_stall=1, stall_s=0001 and flush_s=0010 for 1 cycle, stall_cnt=1.
REQ-036 mem_access=1 with dmem_ready low for 3 cycles -> dmem_req pulses once, en_s=0000 for 3 cycles, return to RUN, stall_cnt=3.
REQ-037 ex_br_taken=1 together with a load-use -> flush_s=0011, pc_stall=0, flush_cnt=1.
REQ-038 ex_ra0=7 with mem_wa=7 (ALU) and wb_wa=7 -> fwd0_sel=01; mem_wd_sel=10 -> 11; ex_ra0=0 -> 00.
REQ-039 rst asserted in MEM_WAIT -> state RUN, counters 0, dmem_req=0 on the reset cycle.
REQ-040 stall_cnt preloaded to 32'hFFFF_FFFF through a force, then a stall -> value held.
